soc_system_pio_out_ext: RTL and testbench

SOC_SYSTEM_PIO_OUT_EXT -- requirements
Module: soc_system_pio_out_ext

---
 rtl/soc_system_pio_out_ext.sv | 137 +++++++++++++
 tb/tb_soc_system_pio_out_ext.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_pio_out_ext.sv
// -----------------------------------------------------------------------------
// soc_system_pio_out_ext
//
// This is an Avalon-MM output port (PIO) with set, clear and toggle write
// aliases. Each output bit can also blink under a common divider.
//
// The register map uses word addresses:
//   0 DATA      (R/W)  output data value
//   1 SET       (W)    DATA |=  writedata  (a read returns DATA)
//   2 CLEAR     (W)    DATA &= ~writedata  (a read returns DATA)
//   3 TOGGLE    (W)    DATA ^=  writedata  (a read returns DATA)
//   4 BLINK_EN  (R/W)  per-bit blink enable
//   5 BLINK_DIV (R/W)  half-period minus one, in clk cycles (0 = no blink)
//   6-7                reserved: reads return 0 and writes are ignored
//
// Ports:
//   clk         sole clock; all state changes on its rising edge
//   reset       asynchronous active-high reset
//   address     Avalon-MM word address
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data; bits above the register width are ignored
//   readdata    combinational read data, zero-extended, ignores chipselect
//   out_port    registered pin value
// -----------------------------------------------------------------------------
module soc_system_pio_out_ext #(
    parameter int          WIDTH       = 19,
    parameter int unsigned RESET_VALUE = 1023,
    parameter int          DIV_WIDTH   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [WIDTH-1:0] RESET_DATA = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0]     data_reg,      data_next;
    logic [WIDTH-1:0]     blink_en_reg,  blink_en_next;
    logic [DIV_WIDTH-1:0] blink_div_reg, blink_div_next;
    logic [DIV_WIDTH-1:0] cnt_reg,       cnt_next;
    logic                 phase_reg,     phase_next;
    logic [WIDTH-1:0]     out_port_reg,  out_port_next;

    logic                 wr_en;
    logic [WIDTH-1:0]     wr_bits;
    logic [DIV_WIDTH-1:0] wr_div;

    assign wr_en   = chipselect & ~write_n;
    assign wr_bits = writedata[WIDTH-1:0];
    assign wr_div  = writedata[DIV_WIDTH-1:0];

    // Register write decode
    always_comb begin
        data_next      = data_reg;
        blink_en_next  = blink_en_reg;
        blink_div_next = blink_div_reg;
        if (wr_en) begin
            case (address)
                3'd0:    data_next      = wr_bits;
                3'd1:    data_next      = data_reg | wr_bits;
                3'd2:    data_next      = data_reg & ~wr_bits;
                3'd3:    data_next      = data_reg ^ wr_bits;
                3'd4:    blink_en_next  = wr_bits;
                3'd5:    blink_div_next = wr_div;
                default: ;
            endcase
        end
    end

    // Blink counter. CNT runs from 0 to BLINK_DIV inclusive, so each phase
    // lasts BLINK_DIV+1 cycles. A divider write restarts the blink in the
    // high phase, and it takes priority over the terminal-count update. The
    // restart also keeps CNT from running past a lowered divider.
    always_comb begin
        cnt_next   = cnt_reg;
        phase_next = phase_reg;
        if (wr_en && address == 3'd5) begin
            cnt_next   = '0;
            phase_next = 1'b1;
        end else if (blink_div_reg == '0) begin
            cnt_next   = '0;
            phase_next = 1'b1;
        end else if (cnt_reg == blink_div_reg) begin
            cnt_next   = '0;
            phase_next = ~phase_reg;
        end else begin
            cnt_next   = cnt_reg + DIV_WIDTH'(1);
        end
    end

    // The pin value is built from the next-state values. This gives exactly
    // one cycle from a write edge to the pin change. A blinking bit is
    // forced low during the low phase.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out_bit
            assign out_port_next[gi] = data_next[gi] & (~blink_en_next[gi] | phase_next);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg      <= RESET_DATA;
            blink_en_reg  <= '0;
            blink_div_reg <= '0;
            cnt_reg       <= '0;
            phase_reg     <= 1'b1;
            out_port_reg  <= RESET_DATA;
        end else begin
            data_reg      <= data_next;
            blink_en_reg  <= blink_en_next;
            blink_div_reg <= blink_div_next;
            cnt_reg       <= cnt_next;
            phase_reg     <= phase_next;
            out_port_reg  <= out_port_next;
        end
    end

    assign out_port = out_port_reg;

    // Read mux: SET, CLEAR and TOGGLE alias DATA on reads
    always_comb begin
        readdata = '0;
        case (address)
            3'd0, 3'd1, 3'd2, 3'd3: readdata[WIDTH-1:0]     = data_reg;
            3'd4:                   readdata[WIDTH-1:0]     = blink_en_reg;
            3'd5:                   readdata[DIV_WIDTH-1:0] = blink_div_reg;
            default:                ;
        endcase
    end

endmodule

// File: tb/tb_soc_system_pio_out_ext.sv
// -----------------------------------------------------------------------------
// tb_soc_system_pio_out_ext
//
// This bench drives soc_system_pio_out_ext through directed bus sequences
// followed by randomized traffic. It checks out_port after every clock edge
// and checks readdata at chosen points against a reference model. The model
// derives the blink phase from the number of cycles since the last divider
// restart.
// -----------------------------------------------------------------------------
module tb_soc_system_pio_out_ext;

    localparam int WIDTH     = 19;
    localparam int DIV_WIDTH = 16;
    localparam logic [WIDTH-1:0] RV = 19'h003FF;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [WIDTH-1:0]  out_port;

    soc_system_pio_out_ext #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(1023),
        .DIV_WIDTH  (DIV_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model state
    logic [WIDTH-1:0]     m_data;
    logic [WIDTH-1:0]     m_en;
    logic [DIV_WIDTH-1:0] m_div;
    int unsigned          m_t;   // edges since the last divider restart

    function automatic logic m_phase();
        if (m_div == 0) return 1'b1;
        return ((m_t / (int'(m_div) + 1)) % 2) == 0;
    endfunction

    function automatic logic [WIDTH-1:0] m_out();
        return m_data & ~(m_en & {WIDTH{~m_phase()}});
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0, 3'd1, 3'd2, 3'd3: return 32'(m_data);
            3'd4:                   return 32'(m_en);
            3'd5:                   return 32'(m_div);
            default:                return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_data = RV;
        m_en   = '0;
        m_div  = '0;
        m_t    = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // One clock edge: advance the model using the inputs driven at that
    // edge, then check the pin shortly after the edge.
    task automatic tick(input string tag);
        logic [WIDTH-1:0] w;
        @(posedge clk);
        w = writedata[WIDTH-1:0];
        if (chipselect && !write_n) begin
            case (address)
                3'd0: m_data = w;
                3'd1: m_data = m_data | w;
                3'd2: m_data = m_data & ~w;
                3'd3: m_data = m_data ^ w;
                3'd4: m_en   = w;
                3'd5: m_div  = writedata[DIV_WIDTH-1:0];
                default: ;
            endcase
        end
        if (chipselect && !write_n && address == 3'd5) m_t = 0;
        else m_t++;
        #1;
        check(tag, 32'(out_port), 32'(m_out()));
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick("out_after_write");
        $display("write addr=%0d data=0x%08h -> out_port=0x%05h", a, d, out_port);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic read_check(input string tag, input logic [2:0] a);
        address = a;
        #1;
        check(tag, readdata, m_read(a));
        $display("read  addr=%0d -> readdata=0x%08h", a, readdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        m_reset();
        #1;
        check("reset_out", 32'(out_port), 32'h0003FF);
        check("reset_rd0", readdata, 32'h000003FF);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Set, clear and toggle sequence
        bus_write(3'd0, 32'h0007FFFF);
        bus_write(3'd2, 32'h0000000F);
        bus_write(3'd1, 32'h00000100);
        bus_write(3'd3, 32'h00000003);
        check("sct_out", 32'(out_port), 32'h0007FFF3);
        read_check("sct_data", 3'd0);
        check("sct_data_const", readdata, 32'h0007FFF3);

        // Upper data bits ignored, reserved address reads 0
        bus_write(3'd0, 32'hFFFFFFFF);
        read_check("trunc_rd", 3'd0);
        check("trunc_const", readdata, 32'h0007FFFF);
        read_check("rsvd6", 3'd6);
        check("rsvd6_const", readdata, 32'h0);
        bus_write(3'd7, 32'h12345678);
        read_check("rsvd7_write_ignored", 3'd0);

        // Mid-cycle reset pulse
        #3 reset = 1'b1;
        #1;
        m_reset();
        check("midreset_out", 32'(out_port), 32'h0003FF);
        address = 3'd0;
        #1;
        check("midreset_rd0", readdata, 32'h000003FF);
        // A write held during reset must be ignored
        chipselect = 1'b1; write_n = 1'b0; writedata = 32'h0; address = 3'd0;
        @(posedge clk); #1;
        check("write_in_reset", 32'(out_port), 32'h0003FF);
        chipselect = 1'b0; write_n = 1'b1;
        reset = 1'b0;

        // Blink with divider 3: 4 cycles high, then 4 cycles low
        bus_write(3'd0, 32'h00000001);
        bus_write(3'd4, 32'h00000001);
        bus_write(3'd5, 32'hABCD0003);   // upper bits must be ignored
        read_check("div_rd", 3'd5);
        check("div_const", readdata, 32'h00000003);
        check("blink_t0", 32'(out_port[0]), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            tick("blink_out");
            check("blink_bit0", 32'(out_port[0]), 32'(((k / 4) % 2) == 0));
            check("blink_others", 32'(out_port[WIDTH-1:1]), 32'd0);
        end
        // k=16 is the start of a high phase, so advance into the low phase
        repeat (5) tick("to_low");
        check("low_phase", 32'(out_port[0]), 32'd0);
        bus_write(3'd5, 32'h00000000);
        check("divzero_out", 32'(out_port[0]), 32'd1);
        repeat (6) tick("divzero_steady");
        check("divzero_steady_bit", 32'(out_port[0]), 32'd1);

        // Reset during the low phase of a blink
        bus_write(3'd5, 32'h00000003);
        repeat (5) tick("to_low2");
        check("low_phase2", 32'(out_port[0]), 32'd0);
        #3 reset = 1'b1;
        #1;
        m_reset();
        check("blinkreset_out", 32'(out_port), 32'h0003FF);
        @(posedge clk); #1;
        reset = 1'b0;
        read_check("blinkreset_en", 3'd4);
        check("blinkreset_en_const", readdata, 32'h0);
        repeat (10) tick("after_reset_steady");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            r = $urandom_range(0, 3);
            if (r == 0) begin
                tick("rand_idle");
            end else begin
                logic [2:0]  a;
                logic [31:0] d;
                a = 3'($urandom_range(0, 7));
                if (a == 3'd5)
                    d = ($urandom & 32'hFFFF0000) | 32'($urandom_range(0, 5));
                else
                    d = $urandom;
                bus_write(a, d);
            end
            read_check("rand_read", 3'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
